// File: rtl/multicycle_control_unit_pkg.sv
// Shared opcodes, ALU encodings, FSM states and trap codes for the multi-cycle control unit.
// Optional LUI support is enabled with the MCU_LUI_EN macro.
package ctrl_pkg;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_SUB    = 2'd1;
  localparam logic [1:0] ALU_R_TYPE = 2'd2;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_IMEM_TO = 2'd2;
  localparam logic [1:0] ERR_DMEM_TO = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CLS_ILLEGAL,
    CLS_R,
    CLS_I,
    CLS_BRANCH,
    CLS_JAL,
    CLS_LOAD,
    CLS_STORE,
    CLS_LUI
  } op_class_t;

  // Anything outside the supported set classifies as illegal and traps in DECODE.
  function automatic op_class_t op_class(input logic [6:0] op);
    op_class_t cls;
    case (op)
      OP_R_TYPE: cls = CLS_R;
      OP_I_TYPE: cls = CLS_I;
      OP_BRANCH: cls = CLS_BRANCH;
      OP_JAL:    cls = CLS_JAL;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
`ifdef MCU_LUI_EN
      OP_LUI:    cls = CLS_LUI;
`else
      OP_LUI:    cls = CLS_ILLEGAL;
`endif
      default:   cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Handshake and control bus between the multi-cycle control unit (master) and
// the instruction register / memories / datapath (slave).
interface multicycle_control_unit_if #(
  parameter int ALU_OP_W = 2
);
  logic                enable;
  logic [6:0]          opcode;
  logic                imem_ready;
  logic                dmem_ready;
  logic                imem_req;
  logic                ir_write;
  logic                pc_write;
  logic [ALU_OP_W-1:0] alu_op;
  logic                alu_src;
  logic                branch;
  logic                jump;
  logic                mem_read;
  logic                mem_write;
  logic                mem_2_reg;
  logic                reg_write;
  logic                busy;
  logic                err;
  logic [1:0]          err_code;

  modport master (
    input  enable, opcode, imem_ready, dmem_ready,
    output imem_req, ir_write, pc_write, alu_op, alu_src, branch, jump,
           mem_read, mem_write, mem_2_reg, reg_write, busy, err, err_code
  );

  modport slave (
    output enable, opcode, imem_ready, dmem_ready,
    input  imem_req, ir_write, pc_write, alu_op, alu_src, branch, jump,
           mem_read, mem_write, mem_2_reg, reg_write, busy, err, err_code
  );
endinterface

// File: rtl/multicycle_control_unit_wait_timer.sv
// Memory wait-state counter shared by FETCH and MEM; flags expiry on the cycle the
// count would reach MAX with the ready still low. MAX of 0 disables expiry.
module wait_timer #(
  parameter int MAX   = 15,
  parameter int CNT_W = $clog2(MAX + 2)
) (
  input  logic clk,
  input  logic arst_n,
  input  logic clr,
  input  logic busy_wait,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((MAX > 0) ? (MAX - 1) : 0);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (busy_wait && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (MAX != 0) && busy_wait && (r_count == LIMIT);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V control FSM: FETCH/DECODE/EXEC/MEM/WB with memory wait timeout
// and illegal-opcode trap. Define MCU_LUI_EN to accept LUI.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int ALU_OP_W     = 2,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                       clk,
  input  logic                       arst_n,
  multicycle_control_unit_if.master  ctrl
);

  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 2);

  state_t     r_state;
  state_t     w_next_state;
  state_t     w_boundary_state;
  logic [6:0] r_opcode_q;
  op_class_t  w_cls;
  logic       r_err;
  logic [1:0] r_err_code;
  logic [1:0] w_trap_code;
  logic       w_timer_clr;
  logic       w_busy_wait;
  logic       w_expired;

  assign w_cls = op_class(r_opcode_q);

  // The timer restarts on every state change, so both FETCH and MEM start counting from zero.
  assign w_timer_clr = (r_state != w_next_state);
  assign w_busy_wait = ((r_state == ST_FETCH) && !ctrl.imem_ready) ||
                       ((r_state == ST_MEM)   && !ctrl.dmem_ready);

  wait_timer #(
    .MAX   (MEM_WAIT_MAX),
    .CNT_W (CNT_W)
  ) u_wait_timer (
    .clk       (clk),
    .arst_n    (arst_n),
    .clr       (w_timer_clr),
    .busy_wait (w_busy_wait),
    .expired   (w_expired)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_opcode_q <= '0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      if ((r_state == ST_FETCH) && ctrl.imem_ready) begin
        r_opcode_q <= ctrl.opcode;
      end
      if ((w_next_state == ST_TRAP) && (r_state != ST_TRAP)) begin
        r_err      <= 1'b1;
        r_err_code <= w_trap_code;
      end
    end
  end

  // enable is only consulted when an instruction retires.
  always_comb begin
    w_next_state     = r_state;
    w_trap_code      = ERR_NONE;
    w_boundary_state = ctrl.enable ? ST_FETCH : ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (ctrl.enable) begin
          w_next_state = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (ctrl.imem_ready) begin
          w_next_state = ST_DECODE;
        end else if (w_expired) begin
          w_next_state = ST_TRAP;
          w_trap_code  = ERR_IMEM_TO;
        end
      end
      ST_DECODE: begin
        if (w_cls == CLS_ILLEGAL) begin
          w_next_state = ST_TRAP;
          w_trap_code  = ERR_ILLEGAL;
        end else begin
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (w_cls)
          CLS_BRANCH:          w_next_state = w_boundary_state;
          CLS_LOAD, CLS_STORE: w_next_state = ST_MEM;
          default:             w_next_state = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (ctrl.dmem_ready) begin
          w_next_state = (w_cls == CLS_LOAD) ? ST_WB : w_boundary_state;
        end else if (w_expired) begin
          w_next_state = ST_TRAP;
          w_trap_code  = ERR_DMEM_TO;
        end
      end
      ST_WB: begin
        w_next_state = w_boundary_state;
      end
      ST_TRAP: begin
        w_next_state = ST_TRAP;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    ctrl.imem_req  = 1'b0;
    ctrl.ir_write  = 1'b0;
    ctrl.pc_write  = 1'b0;
    ctrl.alu_op    = ALU_OP_W'(ALU_ADD);
    ctrl.alu_src   = 1'b0;
    ctrl.branch    = 1'b0;
    ctrl.jump      = 1'b0;
    ctrl.mem_read  = 1'b0;
    ctrl.mem_write = 1'b0;
    ctrl.mem_2_reg = 1'b0;
    ctrl.reg_write = 1'b0;
    ctrl.busy      = (r_state != ST_IDLE) && (r_state != ST_TRAP);
    ctrl.err       = r_err;
    ctrl.err_code  = r_err_code;
    case (r_state)
      ST_FETCH: begin
        ctrl.imem_req = 1'b1;
        ctrl.ir_write = ctrl.imem_ready;
      end
      ST_EXEC: begin
        case (w_cls)
          CLS_R: begin
            ctrl.alu_op = ALU_OP_W'(ALU_R_TYPE);
          end
          CLS_I, CLS_LOAD, CLS_STORE, CLS_LUI: begin
            ctrl.alu_src = 1'b1;
          end
          CLS_BRANCH: begin
            ctrl.alu_op   = ALU_OP_W'(ALU_SUB);
            ctrl.branch   = 1'b1;
            ctrl.pc_write = 1'b1;
          end
          default: begin
            ctrl.alu_src = 1'b0;
          end
        endcase
      end
      ST_MEM: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_read  = (w_cls == CLS_LOAD);
        ctrl.mem_write = (w_cls == CLS_STORE);
        ctrl.pc_write  = (w_cls == CLS_STORE) && ctrl.dmem_ready;
      end
      ST_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.mem_2_reg = (w_cls == CLS_LOAD);
        ctrl.jump      = (w_cls == CLS_JAL);
      end
      default: begin
        ctrl.imem_req = 1'b0;
      end
    endcase
  end

endmodule
